// File: rtl/enigma_pkg.sv
`default_nettype none
// =====================================================================
// Module : enigma_pkg
// Brief  : shared types and notch->step mapping for the Enigma sequencer.
//          Build option: ENIGMA_DOUBLE_STEP_EN selects double-step stepping.
// Rev    : 1.0  initial release
// =====================================================================
package enigma_pkg;

   typedef logic [4:0] letter_t;

   localparam int ALPHA_LEN = 26;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STEP   = 3'd2,
      SETTLE = 3'd3,
      OUT    = 3'd4
   } ctrl_state_e;

   // Bit 0 is the fast rotor; notch flags reflect positions before this step.
   function automatic logic [2:0] step_vec(input logic [2:0] notch);
`ifdef ENIGMA_DOUBLE_STEP_EN
      step_vec = {notch[1], notch[0] | notch[1], 1'b1};
`else
      step_vec = {notch[0] & notch[1], notch[0], 1'b1};
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_step_logic.sv
`default_nettype none
// =====================================================================
// Module : enigma_step_logic
// Brief  : combinational notch->step pulse mapping, gated by enable.
//          Build option: ENIGMA_DOUBLE_STEP_EN (via enigma_pkg::step_vec).
// Rev    : 1.0  initial release
// =====================================================================
module enigma_step_logic
   import enigma_pkg::*;
#(
   parameter int NUM_ROTORS = 3
)(
   input  logic                  i_enable,
   input  logic [NUM_ROTORS-1:0] i_notch,
   output logic [NUM_ROTORS-1:0] o_step
);

   always_comb begin
      o_step = '0;
      if (i_enable) begin
         o_step = step_vec(i_notch);
      end
   end

endmodule
`default_nettype wire

// File: rtl/enigma_step_ctrl.sv
`default_nettype none
// =====================================================================
// Module : enigma_step_ctrl
// Brief  : letter/key sequencer for the 3-rotor Enigma datapath.
//          Build option: ENIGMA_DOUBLE_STEP_EN (historical double-step).
// Rev    : 1.0  initial release
// =====================================================================
module enigma_step_ctrl
   import enigma_pkg::*;
#(
   parameter int NUM_ROTORS    = 3,
   parameter int SETTLE_CYCLES = 1
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            in_char,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4:0]            out_char,
   output logic                  in_err,
   input  logic                  cfg_load,
   output logic                  cfg_busy,
   output logic                  load_key_o,
   output logic [NUM_ROTORS-1:0] step_o,
   input  logic [NUM_ROTORS-1:0] notch_i,
   output logic [4:0]            dp_char_o,
   input  logic [4:0]            dp_char_i
);

   localparam logic [3:0] c_settle_init = 4'(SETTLE_CYCLES - 1);
   localparam letter_t    c_last_letter = letter_t'(ALPHA_LEN - 1);

   ctrl_state_e r_state;
   ctrl_state_e w_state_nxt;
   letter_t     r_dp_char;
   letter_t     w_dp_char_nxt;
   letter_t     r_out_char;
   letter_t     w_out_char_nxt;
   logic        r_out_valid;
   logic        w_out_valid_nxt;
   logic        r_in_err;
   logic        w_in_err_nxt;
   logic [3:0]  r_settle_cnt;
   logic [3:0]  w_settle_cnt_nxt;
   logic        w_in_ready;
   logic        w_load_key;
   logic        w_step_en;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_dp_char    <= '0;
         r_out_char   <= '0;
         r_out_valid  <= 1'b0;
         r_in_err     <= 1'b0;
         r_settle_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_dp_char    <= w_dp_char_nxt;
         r_out_char   <= w_out_char_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_in_err     <= w_in_err_nxt;
         r_settle_cnt <= w_settle_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_dp_char_nxt    = r_dp_char;
      w_out_char_nxt   = r_out_char;
      w_out_valid_nxt  = r_out_valid;
      w_in_err_nxt     = 1'b0;
      w_settle_cnt_nxt = r_settle_cnt;
      w_in_ready       = 1'b0;
      w_load_key       = 1'b0;
      w_step_en        = 1'b0;

      case (r_state)
         IDLE: begin
            w_in_ready = ~cfg_load;
            // Key load wins; a simultaneous letter stays pending upstream.
            if (cfg_load) begin
               w_state_nxt = LOAD;
            end else if (in_valid) begin
               if (in_char > c_last_letter) begin
                  w_in_err_nxt = 1'b1;
               end else begin
                  w_dp_char_nxt = in_char;
                  w_state_nxt   = STEP;
               end
            end
         end
         LOAD: begin
            w_load_key  = 1'b1;
            w_state_nxt = IDLE;
         end
         STEP: begin
            w_step_en        = 1'b1;
            w_settle_cnt_nxt = c_settle_init;
            w_state_nxt      = SETTLE;
         end
         SETTLE: begin
            if (r_settle_cnt == 4'd0) begin
               w_out_char_nxt  = dp_char_i;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = OUT;
            end else begin
               w_settle_cnt_nxt = r_settle_cnt - 4'd1;
            end
         end
         OUT: begin
            if (out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   enigma_step_logic #(
      .NUM_ROTORS (NUM_ROTORS)
   ) u_step_logic (
      .i_enable (w_step_en),
      .i_notch  (notch_i),
      .o_step   (step_o)
   );

   assign in_ready   = w_in_ready;
   assign out_valid  = r_out_valid;
   assign out_char   = r_out_char;
   assign in_err     = r_in_err;
   assign cfg_busy   = (r_state != IDLE);
   assign load_key_o = w_load_key;
   assign dp_char_o  = r_dp_char;

endmodule
`default_nettype wire

// File: tb/tb_enigma_step_ctrl.sv
`default_nettype none
// =====================================================================
// Module : tb_enigma_step_ctrl
// Brief  : self-checking bench for enigma_step_ctrl with a mock datapath.
// Rev    : 1.0  initial release
// =====================================================================
module tb_enigma_step_ctrl;

   localparam int SETTLE = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [4:0] in_char = 5'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [4:0] out_char;
   logic       in_err;
   logic       cfg_load = 1'b0;
   logic       cfg_busy;
   logic       load_key_o;
   logic [2:0] step_o;
   logic [2:0] notch_i = 3'b000;
   logic [4:0] dp_char_o;
   logic [4:0] dp_char_i;

   int total = 0;
   int bad = 0;
   int step_cnt = 0;
   int load_cnt = 0;
   logic [4:0] exp_q[$];

   typedef struct {
      logic [4:0] c;
      logic [2:0] notch;
      logic [2:0] step;
      logic       err;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   function automatic logic [4:0] cipher(input logic [4:0] c);
      return 5'((int'(c) * 7 + 3) % 26);
   endfunction

   assign dp_char_i = cipher(dp_char_o);

   enigma_step_ctrl #(
      .NUM_ROTORS    (3),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_char    (in_char),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_char   (out_char),
      .in_err     (in_err),
      .cfg_load   (cfg_load),
      .cfg_busy   (cfg_busy),
      .load_key_o (load_key_o),
      .step_o     (step_o),
      .notch_i    (notch_i),
      .dp_char_o  (dp_char_o),
      .dp_char_i  (dp_char_i)
   );

   function automatic logic [2:0] ref_step(input logic [2:0] n);
`ifdef ENIGMA_DOUBLE_STEP_EN
      return {n[1], n[0] | n[1], 1'b1};
`else
      return {n[0] & n[1], n[0], 1'b1};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: step pulses, key loads and the output-stream scoreboard.
   always @(negedge clk) begin
      if (reset_n) begin
         if (step_o != 3'b000) begin
            step_cnt++;
            check("step_vs_notch", step_o, ref_step(notch_i));
            check("step_load_excl", load_key_o, 0);
         end
         if (load_key_o) load_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else check("sb_out_char", out_char, exp_q.pop_front());
         end
      end
   end

   task automatic wait_out(input int budget);
      int n;
      n = 0;
      while (!out_valid && n < budget) begin
         tick();
         n++;
      end
      check("wait_out_timeout", out_valid, 1);
   endtask

   task automatic send_letter(input vec_t v);
      int sc0;
      sc0 = step_cnt;
      in_char  = v.c;
      notch_i  = v.notch;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      check("in_ready_idle", in_ready, 1);
      if (!v.err) exp_q.push_back(cipher(v.c));
      tick();
      in_valid = 1'b0;
      if (v.err) begin
         check("err_pulse", in_err, 1);
         check("err_no_step", step_o, 0);
         tick();
         check("err_one_cycle", in_err, 0);
         check("err_idle", in_ready, 1);
         check("err_step_cnt", step_cnt - sc0, 0);
      end else begin
         check("step_o", step_o, v.step);
         check("dp_char_o", dp_char_o, v.c);
         check("in_ready_busy", in_ready, 0);
         for (int i = 1; i <= SETTLE; i++) begin
            tick();
            check("out_valid_early", out_valid, 0);
         end
         tick();
         check("out_valid_lat", out_valid, 1);
         check("out_char", out_char, cipher(v.c));
         check("step_once", step_cnt - sc0, 1);
         tick();
         check("out_valid_drop", out_valid, 0);
         check("back_idle", in_ready, 1);
      end
   endtask

   initial begin
      int sc0;
      int lc0;
      logic [4:0] held;

      vecs[0] = '{5'd0,  3'b000, 3'b001, 1'b0};
      vecs[1] = '{5'd5,  3'b001, 3'b011, 1'b0};
      vecs[2] = '{5'd25, 3'b011, 3'b111, 1'b0};
`ifdef ENIGMA_DOUBLE_STEP_EN
      vecs[3] = '{5'd12, 3'b010, 3'b111, 1'b0};
      vecs[7] = '{5'd3,  3'b110, 3'b111, 1'b0};
`else
      vecs[3] = '{5'd12, 3'b010, 3'b001, 1'b0};
      vecs[7] = '{5'd3,  3'b110, 3'b001, 1'b0};
`endif
      vecs[4] = '{5'd26, 3'b000, 3'b000, 1'b1};
      vecs[5] = '{5'd31, 3'b011, 3'b000, 1'b1};
      vecs[6] = '{5'd7,  3'b100, 3'b001, 1'b0};
      vecs[8] = '{5'd20, 3'b101, 3'b011, 1'b0};

      // Reset state, sampled while reset is still asserted.
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_char", out_char, 0);
      check("rst_in_err", in_err, 0);
      check("rst_load_key", load_key_o, 0);
      check("rst_step", step_o, 0);
      check("rst_dp_char", dp_char_o, 0);
      check("rst_busy", cfg_busy, 0);
      reset_n = 1'b1;
      tick();

      // Key load.
      lc0 = load_cnt;
      cfg_load = 1'b1;
      #1;
      check("cfg_load_blocks_ready", in_ready, 0);
      tick();
      cfg_load = 1'b0;
      check("load_key_on", load_key_o, 1);
      check("load_busy", cfg_busy, 1);
      check("load_ready", in_ready, 0);
      tick();
      check("load_key_off", load_key_o, 0);
      check("load_once", load_cnt - lc0, 1);

      for (int i = 0; i < 9; i++) send_letter(vecs[i]);

      // cfg_load and in_valid together: load first, letter afterwards.
      sc0 = step_cnt;
      lc0 = load_cnt;
      cfg_load = 1'b1;
      in_valid = 1'b1;
      in_char  = 5'd9;
      notch_i  = 3'b000;
      exp_q.push_back(cipher(5'd9));
      tick();
      cfg_load = 1'b0;
      check("prio_load", load_key_o, 1);
      tick();
      check("prio_idle_ready", in_ready, 1);
      check("prio_no_step_yet", step_cnt - sc0, 0);
      tick();
      in_valid = 1'b0;
      check("prio_step", step_o, 3'b001);
      check("prio_dp", dp_char_o, 9);
      wait_out(20);
      tick();
      check("prio_load_once", load_cnt - lc0, 1);

      // Backpressure with a pending letter and an ignored cfg_load.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_char   = 5'd4;
      notch_i   = 3'b001;
      exp_q.push_back(cipher(5'd4));
      tick();
      in_valid = 1'b0;
      wait_out(20);
      held = out_char;
      check("bp_char", held, cipher(5'd4));
      sc0 = step_cnt;
      lc0 = load_cnt;
      in_valid = 1'b1;
      in_char  = 5'd10;
      notch_i  = 3'b000;
      cfg_load = 1'b1;
      exp_q.push_back(cipher(5'd10));
      for (int i = 0; i < 5; i++) begin
         check("bp_valid_held", out_valid, 1);
         check("bp_char_held", out_char, held);
         check("bp_not_ready", in_ready, 0);
         tick();
      end
      check("bp_no_step", step_cnt - sc0, 0);
      check("bp_no_load", load_cnt - lc0, 0);
      cfg_load  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", out_valid, 0);
      check("bp_release_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp_next_step", step_o, 3'b001);
      check("bp_next_dp", dp_char_o, 10);
      wait_out(20);
      tick();

      // Reset during SETTLE aborts the letter.
      in_valid = 1'b1;
      in_char  = 5'd15;
      notch_i  = 3'b011;
      tick();
      in_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      check("rs_out_valid", out_valid, 0);
      check("rs_step", step_o, 0);
      check("rs_ready", in_ready, 1);
      check("rs_dp", dp_char_o, 0);
      reset_n = 1'b1;
      tick();
      check("rs_no_output", out_valid, 0);
      send_letter(vecs[1]);
      check("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
